nibble_serial_add_ctrl: RTL

Sequencer placed directly around the team's 4-bit ripple-carry adder. It accepts a WIDTH-bit operand pair through a valid/ready handshake and feeds the adder one nibble per cycle, LSB nibble first. Each cycle it captures the adder's sum and carry-out, and routes the carry back into the next nibble. It presents the full WIDTH-bit result and final carry on a valid/ready output. Multi-nibble additions therefore reuse a single 4-bit adder instance.

---
 rtl/nibble_serial_add_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Sequencer wrapped around an external combinational 4-bit ripple-carry adder.
// It accepts a WIDTH-bit operand pair, feeds the adder one nibble per cycle
// (LSB nibble first), and chains the adder carry-out into the next nibble.
// When all nibbles are done it presents the full sum and the final carry.
//
// Parameters
//   WIDTH     operand/result width; must be a multiple of 4 and >= 4
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; in_a, in_b, in_cin operands
//   rca_a/rca_b/rca_cin  nibble operands and carry driven to the adder
//   rca_sum/rca_cout     combinational result returned by the adder
//   out_valid/out_ready  result handshake; out_sum, out_cout result
//   busy                 high while an operation is in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       rca_a,
  output logic [3:0]       rca_b,
  output logic             rca_cin,
  input  logic [3:0]       rca_sum,
  input  logic             rca_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  // A one-nibble instance still needs a 1-bit index.
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last_nib;

  assign last_nib = (idx == IW'(NIB - 1));

  // Adder result enters at the top of the sum register so that after NIB
  // shifts the LSB nibble has arrived at bit 0. Written as shift-then-overlay
  // so the WIDTH=4 case needs no special slicing.
  always_comb begin
    sum_nx                = sum_sh >> 4;
    sum_nx[WIDTH-1 -: 4]  = rca_sum;
  end

  // NOTE: every output and next-state value gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    rca_a     = 4'd0;
    rca_b     = 4'd0;
    rca_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        rca_a   = a_sh[3:0];
        rca_b   = b_sh[3:0];
        rca_cin = carry;
        if (last_nib) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = sum_sh;
        out_cout  = carry;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values, matching the hardware.
  // NOTE: every register here is reset, so an aborted operation leaves no
  // stale operand or partial sum behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= in_a;
            b_sh   <= in_b;
            carry  <= in_cin;
            idx    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_nx;
          carry  <= rca_cout;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          idx    <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
